regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 32x32 register file between the pipeline writeback stage (wb) and a multi-cycle execution unit (mc). It registers the granted write onto the regfile write port and guarantees bounded mc wait via a starvation override that stalls the pipeline. It also optionally bypasses the in-flight write onto the two regfile read paths.

## Interface
- STARVE_LIMIT, 4: consecutive blocked mc cycles before override; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wb_valid  in  1  writeback write request; no backpressure except via pipe_stall.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- mc_valid  in  1  mc write request; held until accepted.
- mc_addr  in  5  mc destination register.
- mc_data  in  32  mc data.
- mc_ready  out  1  combinational; mc write accepted this cycle.
- pipe_stall  out  1  combinational; wb write not taken this cycle, pipeline holds wb_* stable.
- rf_we  out  1  registered; regfile RegWrite.
- rf_waddr  out  5  registered; regfile write register.
- rf_wdata  out  32  registered; regfile write data.
- rd_addr1, rd_addr2  in  5 each  read addresses presented to the regfile.
- rf_rdata1, rf_rdata2  in  32 each  regfile read data.
- rd_data1, rd_data2  out  32 each  read data to consumers.

## Operation
- wb_req = wb_valid && wb_addr != 0; mc_req = mc_valid && mc_addr != 0.
- Register 0 never written: mc_valid with mc_addr 0 gets mc_ready=1 same cycle and is discarded; wb with addr 0 is ignored, no stall.
- FSM states: NORMAL, OVERRIDE. Counter wait_cnt, width sized for STARVE_LIMIT.
- NORMAL: wb_req granted; else mc_req granted (mc_ready=1). mc_req blocked by wb_req -> wait_cnt+1; when incremented value reaches STARVE_LIMIT -> next state OVERRIDE. pipe_stall=0.
- OVERRIDE: mc_req granted, mc_ready=1; pipe_stall = wb_req; next state NORMAL. If mc_valid is low in OVERRIDE (protocol violation), wb granted normally, return to NORMAL.
- wait_cnt clears on any mc grant, when mc_valid low, and on entry to NORMAL from OVERRIDE.
- Granted write latched into rf_we/rf_waddr/rf_wdata at next edge; no grant -> rf_we=0, addr/data hold previous value.
- Same-address contention in override: mc written first, stalled wb next cycle; wb is final value.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, state NORMAL, wait_cnt=0; mc_ready/pipe_stall follow combinational rules from reset state.
- Reset asserted mid-OVERRIDE: state, counter, outputs forced to reset values immediately; pending mc request re-arbitrates from zero.

## Timing
- Grant in cycle N -> rf_we=1 during N+1 -> regfile commit at end of N+1.
- mc worst-case acceptance: STARVE_LIMIT+1 cycles after mc_valid rises under continuous wb traffic.
- pipe_stall never asserted two consecutive cycles; at most one stall per STARVE_LIMIT+1 cycles.
- mc_ready and pipe_stall depend combinationally on inputs and state only, not on rf_* outputs.

## Configuration
- RFARB_BYPASS_EN defined: rd_dataK = rf_wdata when rf_we && rf_waddr == rd_addrK && rd_addrK != 0, else rf_rdataK (K=1,2); combinational.
- Undefined: rd_dataK = rf_rdataK pass-through; rd_addr inputs unused.

## Test plan
- Reset: rst_n low with wb_valid=1 -> rf_we=0, rf_waddr=0, rf_wdata=0; release, wb addr 2 data 20 -> rf_we=1 addr 2 data 20 next cycle.
- wb only: wb_valid addr 5 data 0x28 at cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0x28 in N+1, rf_we=0 in N+2 after wb_valid drops.
- Starvation, STARVE_LIMIT=4: continuous wb addr 3, mc_valid addr 9 data 0x23 -> mc_ready=0 for 4 cycles, 5th cycle mc_ready=1 and pipe_stall=1; rf writes addr 9 then addr 3 on following cycles.
- Zero register: wb_valid addr 0 -> rf_we=0, no stall; mc_valid addr 0 -> mc_ready=1 same cycle, rf_we=0.
- Bypass: rf_we=1 addr 7 data 0x35, rd_addr1=7, rf_rdata1=0 -> rd_data1=0x35 with RFARB_BYPASS_EN, 0 without; rd_addr2=0 with rf_waddr 0 scenario -> rf_rdata2 passed.
- Reset mid-override: rst_n low in OVERRIDE cycle -> rf_we=0 immediately, state NORMAL; after release mc_ready waits full STARVE_LIMIT again under wb traffic.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single regfile write port between writeback (wb) and a multi-cycle unit (mc),
// with a starvation override for mc. Optional read bypass when RFARB_BYPASS_EN is defined.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_addr,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [31:0] rd_data1,
  output logic [31:0] rd_data2
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(STARVE_LIMIT);

  typedef enum logic {StNormal, StOverride} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  logic            wb_req, mc_req;
  logic            grant_wb, grant_mc;

  // Writes to register 0 are never requests; mc still gets its handshake so it can move on.
  assign wb_req       = wb_valid && (wb_addr != 5'd0);
  assign mc_req       = mc_valid && (mc_addr != 5'd0);
  assign wait_cnt_inc = wait_cnt_q + CntW'(1);

  always_comb begin
    grant_wb   = 1'b0;
    grant_mc   = 1'b0;
    mc_ready   = 1'b0;
    pipe_stall = 1'b0;
    state_d    = StNormal;
    wait_cnt_d = '0;
    unique case (state_q)
      StOverride: begin
        // mc wins; a wb request is held back one cycle and lands afterwards.
        if (mc_req) begin
          grant_mc   = 1'b1;
          pipe_stall = wb_req;
        end else begin
          grant_wb = wb_req;
        end
        mc_ready = mc_valid;
      end
      default: begin
        if (wb_req) begin
          grant_wb = 1'b1;
          if (mc_req) begin
            wait_cnt_d = wait_cnt_inc;
            if (wait_cnt_inc >= CntLimit) begin
              state_d = StOverride;
            end
          end
        end else begin
          grant_mc = mc_req;
        end
        mc_ready = mc_valid && (!mc_req || !wb_req);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StNormal;
      wait_cnt_q <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rf_we      <= grant_wb || grant_mc;
      if (grant_mc) begin
        rf_waddr <= mc_addr;
        rf_wdata <= mc_data;
      end else if (grant_wb) begin
        rf_waddr <= wb_addr;
        rf_wdata <= wb_data;
      end
    end
  end

`ifdef RFARB_BYPASS_EN
  // Forward the write being committed this cycle so readers never see stale data.
  assign rd_data1 = (rf_we && (rf_waddr == rd_addr1) && (rd_addr1 != 5'd0)) ? rf_wdata
                                                                             : rf_rdata1;
  assign rd_data2 = (rf_we && (rf_waddr == rd_addr2) && (rd_addr2 != 5'd0)) ? rf_wdata
                                                                             : rf_rdata2;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign rd_data1       = rf_rdata1;
  assign rd_data2       = rf_rdata2;
`endif

`ifndef SYNTHESIS
  stall_not_back_to_back: assert property (
    @(posedge clk) disable iff (!rst_n) pipe_stall |=> !pipe_stall);
  single_grant: assert property (
    @(posedge clk) disable iff (!rst_n) !(grant_wb && grant_mc));
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a
// waiting-time reference model.
module tb_regfile_write_arbiter;

  localparam int unsigned StarveLimit = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, mc_valid;
  logic [4:0]  wb_addr, mc_addr, rd_addr1, rd_addr2;
  logic [31:0] wb_data, mc_data, rf_rdata1, rf_rdata2;
  logic        mc_ready, pipe_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rd_data1, rd_data2;

  regfile_write_arbiter #(.STARVE_LIMIT(StarveLimit)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .mc_valid  (mc_valid),
    .mc_addr   (mc_addr),
    .mc_data   (mc_data),
    .mc_ready  (mc_ready),
    .pipe_stall(pipe_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected regfile write port and how long mc has been kept waiting.
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  int          mc_wait;
  logic        last_ready, last_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_we     = 1'b0;
    exp_waddr  = 5'd0;
    exp_wdata  = 32'd0;
    mc_wait    = 0;
    last_ready = 1'b0;
    last_stall = 1'b0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic [31:0] rf);
`ifdef RFARB_BYPASS_EN
    return (exp_we && exp_waddr == a && a != 5'd0) ? exp_wdata : rf;
`else
    return rf;
`endif
  endfunction

  // One clock: check combinational outputs mid-cycle, then the registered write after the edge.
  task automatic run_cycle();
    logic wreq, mreq, g_mc, g_wb, e_stall, e_ready;
    @(negedge clk);
    wreq    = wb_valid && (wb_addr != 5'd0);
    mreq    = mc_valid && (mc_addr != 5'd0);
    // mc wins when unopposed, or once it has waited the full starvation limit.
    g_mc    = mreq && (!wreq || mc_wait >= int'(StarveLimit));
    e_stall = wreq && g_mc;
    g_wb    = wreq && !g_mc;
    e_ready = mc_valid && (mc_addr == 5'd0 || g_mc);
    check_eq("mc_ready", 32'(mc_ready), 32'(e_ready));
    check_eq("pipe_stall", 32'(pipe_stall), 32'(e_stall));
    check_eq("rd_data1", rd_data1, exp_read(rd_addr1, rf_rdata1));
    check_eq("rd_data2", rd_data2, exp_read(rd_addr2, rf_rdata2));
    mc_wait    = (mreq && !g_mc) ? mc_wait + 1 : 0;
    last_ready = e_ready;
    last_stall = e_stall;
    @(posedge clk);
    #1;
    if (g_mc) begin
      exp_we = 1'b1; exp_waddr = mc_addr; exp_wdata = mc_data;
    end else if (g_wb) begin
      exp_we = 1'b1; exp_waddr = wb_addr; exp_wdata = wb_data;
    end else begin
      exp_we = 1'b0;
    end
    check_eq("rf_we", 32'(rf_we), 32'(exp_we));
    check_eq("rf_waddr", 32'(rf_waddr), 32'(exp_waddr));
    check_eq("rf_wdata", rf_wdata, exp_wdata);
  endtask

  initial begin
    rst_n     = 1'b0;
    wb_valid  = 1'b1; wb_addr = 5'd2; wb_data = 32'd20;
    mc_valid  = 1'b0; mc_addr = 5'd0; mc_data = 32'd0;
    rd_addr1  = 5'd0; rd_addr2 = 5'd0; rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
    model_reset();

    // Reset holds the write port idle even with a wb request present.
    #12;
    check_eq("rst_we", 32'(rf_we), 32'd0);
    check_eq("rst_waddr", 32'(rf_waddr), 32'd0);
    check_eq("rst_wdata", rf_wdata, 32'd0);
    check_eq("rst_stall", 32'(pipe_stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle();
    check_eq("first_wb_addr", 32'(rf_waddr), 32'd2);
    check_eq("first_wb_data", rf_wdata, 32'd20);

    // wb only, then idle.
    wb_addr = 5'd5; wb_data = 32'h28;
    run_cycle();
    check_eq("wb_only_addr", 32'(rf_waddr), 32'd5);
    wb_valid = 1'b0;
    run_cycle();
    check_eq("wb_idle_we", 32'(rf_we), 32'd0);

    // Starvation under continuous wb traffic.
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h23;
    for (int k = 0; k <= int'(StarveLimit); k++) begin
      run_cycle();
      check_eq("starve_ready", 32'(last_ready), (k == int'(StarveLimit)) ? 32'd1 : 32'd0);
    end
    check_eq("override_mc_addr", 32'(rf_waddr), 32'd9);
    check_eq("override_mc_data", rf_wdata, 32'h23);
    mc_valid = 1'b0;
    run_cycle();
    check_eq("stalled_wb_addr", 32'(rf_waddr), 32'd3);
    check_eq("post_override_stall", 32'(last_stall), 32'd0);

    // Zero register on both requesters.
    wb_addr = 5'd0;
    run_cycle();
    check_eq("zero_wb_we", 32'(rf_we), 32'd0);
    wb_valid = 1'b0; mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'hdead;
    run_cycle();
    check_eq("zero_mc_ready", 32'(last_ready), 32'd1);
    check_eq("zero_mc_we", 32'(rf_we), 32'd0);
    mc_valid = 1'b0;

    // Bypass of an in-flight write to register 7.
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h35;
    run_cycle();
    wb_valid = 1'b0;
    rd_addr1 = 5'd7; rf_rdata1 = 32'd0; rd_addr2 = 5'd0; rf_rdata2 = 32'h77;
    #2;
`ifdef RFARB_BYPASS_EN
    check_eq("bypass_rd1", rd_data1, 32'h35);
`else
    check_eq("bypass_rd1", rd_data1, 32'd0);
`endif
    check_eq("bypass_rd2_zero", rd_data2, 32'h77);
    run_cycle();

    // Reset in the middle of an override cycle.
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 32'h99;
    for (int k = 0; k < int'(StarveLimit); k++) run_cycle();
    #2;
    check_eq("pre_rst_ready", 32'(mc_ready), 32'd1);
    check_eq("pre_rst_stall", 32'(pipe_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(rf_we), 32'd0);
    check_eq("mid_rst_waddr", 32'(rf_waddr), 32'd0);
    check_eq("mid_rst_ready", 32'(mc_ready), 32'd0);
    check_eq("mid_rst_stall", 32'(pipe_stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k <= int'(StarveLimit); k++) begin
      run_cycle();
      check_eq("rearb_ready", 32'(last_ready), (k == int'(StarveLimit)) ? 32'd1 : 32'd0);
    end
    mc_valid = 1'b0;
    run_cycle();

    // Random traffic obeying the hold rules for mc and stalled wb.
    for (int i = 0; i < 3000; i++) begin
      if (!(mc_valid && !last_ready)) begin
        mc_valid = ($urandom_range(0, 2) == 0);
        mc_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        mc_data  = $urandom;
      end
      if (!last_stall) begin
        wb_valid = ($urandom_range(0, 3) != 0);
        wb_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
        wb_data  = $urandom;
      end
      rd_addr1  = $urandom_range(0, 1) ? exp_waddr : 5'($urandom);
      rd_addr2  = $urandom_range(0, 1) ? exp_waddr : 5'($urandom);
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
